// File: rtl/scr1_memif_pkg.sv
// Shared memory-interface types for the SCR1 data-memory path.
// Covers request command/width/response encodings and dmem router selectors.
package scr1_memif_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD,
        SCR1_MEM_CMD_WR
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE,
        SCR1_MEM_WIDTH_HWORD,
        SCR1_MEM_WIDTH_WORD,
        SCR1_MEM_WIDTH_ERROR
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY,
        SCR1_MEM_RESP_RDY_OK,
        SCR1_MEM_RESP_RDY_ER
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        SCR1_SEL_PORT0,
        SCR1_SEL_PORT1,
        SCR1_SEL_PORT2
    } type_scr1_dmem_router_sel_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ABORT
    } type_scr1_dmem_router_fsm_e;

endpackage

// File: rtl/scr1_dmem_router_decode.sv
// Address decoder for the dmem router: port1 (TCM) wins over port2 (timer),
// anything unmatched goes to port0 (AHB bridge).
module scr1_dmem_router_decode
    import scr1_memif_pkg::*;
#(
    parameter logic [31:0] PORT1_ADDR_MASK    = 32'hFFFF_0000,
    parameter logic [31:0] PORT1_ADDR_PATTERN = 32'h0048_0000,
    parameter logic [31:0] PORT2_ADDR_MASK    = 32'hFFFF_FFE0,
    parameter logic [31:0] PORT2_ADDR_PATTERN = 32'h0049_0000
) (
    input  logic [31:0]                addr_i,
    output type_scr1_dmem_router_sel_e sel_o
);

    logic hit1;
    logic hit2;

    assign hit1 = (addr_i & PORT1_ADDR_MASK) == PORT1_ADDR_PATTERN;
    assign hit2 = (addr_i & PORT2_ADDR_MASK) == PORT2_ADDR_PATTERN;

    always_comb begin
        sel_o = SCR1_SEL_PORT0;
        if (hit1) begin
            sel_o = SCR1_SEL_PORT1;
        end else if (hit2) begin
            sel_o = SCR1_SEL_PORT2;
        end
    end

endmodule

// File: rtl/scr1_dmem_router.sv
// Core dmem router to AHB bridge (port0), TCM (port1) and timer (port2).
// Define SCR1_DMEM_ROUTER_TIMEOUT_EN to enable the response timeout / ABORT state.
module scr1_dmem_router
    import scr1_memif_pkg::*;
#(
    parameter logic [31:0] PORT1_ADDR_MASK    = 32'hFFFF_0000,
    parameter logic [31:0] PORT1_ADDR_PATTERN = 32'h0048_0000,
    parameter logic [31:0] PORT2_ADDR_MASK    = 32'hFFFF_FFE0,
    parameter logic [31:0] PORT2_ADDR_PATTERN = 32'h0049_0000
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES     = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dmem_req_i,
    input  type_scr1_mem_cmd_e   dmem_cmd_i,
    input  type_scr1_mem_width_e dmem_width_i,
    input  logic [31:0]          dmem_addr_i,
    input  logic [31:0]          dmem_wdata_i,
    output logic                 dmem_req_ack_o,
    output logic [31:0]          dmem_rdata_o,
    output type_scr1_mem_resp_e  dmem_resp_o,
    output logic                 port0_req_o,
    output type_scr1_mem_cmd_e   port0_cmd_o,
    output type_scr1_mem_width_e port0_width_o,
    output logic [31:0]          port0_addr_o,
    output logic [31:0]          port0_wdata_o,
    input  logic                 port0_req_ack_i,
    input  logic [31:0]          port0_rdata_i,
    input  type_scr1_mem_resp_e  port0_resp_i,
    output logic                 port1_req_o,
    output type_scr1_mem_cmd_e   port1_cmd_o,
    output type_scr1_mem_width_e port1_width_o,
    output logic [31:0]          port1_addr_o,
    output logic [31:0]          port1_wdata_o,
    input  logic                 port1_req_ack_i,
    input  logic [31:0]          port1_rdata_i,
    input  type_scr1_mem_resp_e  port1_resp_i,
    output logic                 port2_req_o,
    output type_scr1_mem_cmd_e   port2_cmd_o,
    output type_scr1_mem_width_e port2_width_o,
    output logic [31:0]          port2_addr_o,
    output logic [31:0]          port2_wdata_o,
    input  logic                 port2_req_ack_i,
    input  logic [31:0]          port2_rdata_i,
    input  type_scr1_mem_resp_e  port2_resp_i
);

    type_scr1_dmem_router_fsm_e state_d, state_q;
    type_scr1_dmem_router_sel_e sel_d, sel_q, sel_dec;
    type_scr1_mem_resp_e        port_resp [3];
    type_scr1_mem_resp_e        resp_cur;
    logic [31:0]                port_rdata [3];
    logic [2:0]                 port_ack;
    logic [2:0]                 port_req;
    logic                       fwd;
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
    logic [7:0]                 cnt_d, cnt_q;
`endif

    scr1_dmem_router_decode #(
        .PORT1_ADDR_MASK    (PORT1_ADDR_MASK),
        .PORT1_ADDR_PATTERN (PORT1_ADDR_PATTERN),
        .PORT2_ADDR_MASK    (PORT2_ADDR_MASK),
        .PORT2_ADDR_PATTERN (PORT2_ADDR_PATTERN)
    ) u_decode (
        .addr_i (dmem_addr_i),
        .sel_o  (sel_dec)
    );

    assign port_resp[0]  = port0_resp_i;
    assign port_resp[1]  = port1_resp_i;
    assign port_resp[2]  = port2_resp_i;
    assign port_rdata[0] = port0_rdata_i;
    assign port_rdata[1] = port1_rdata_i;
    assign port_rdata[2] = port2_rdata_i;
    assign port_ack      = {port2_req_ack_i, port1_req_ack_i, port0_req_ack_i};
    assign resp_cur      = port_resp[sel_q];

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        port_req       = '0;
        dmem_req_ack_o = 1'b0;
        dmem_resp_o    = SCR1_MEM_RESP_NOTRDY;
        dmem_rdata_o   = '0;
        fwd            = 1'b0;
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif
        unique case (state_q)
            IDLE: fwd = 1'b1;
            WAIT: begin
                dmem_resp_o  = resp_cur;
                dmem_rdata_o = port_rdata[sel_q];
                if (resp_cur != SCR1_MEM_RESP_NOTRDY) begin
                    fwd     = 1'b1;
                    state_d = IDLE;
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    dmem_resp_o = SCR1_MEM_RESP_RDY_ER;
                    state_d     = ABORT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
            // Drain the late response of the timed-out target, hidden from the core.
            ABORT: begin
                if (resp_cur != SCR1_MEM_RESP_NOTRDY) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (fwd && rst_n) begin
            port_req[sel_dec] = dmem_req_i;
            dmem_req_ack_o    = dmem_req_i & port_ack[sel_dec];
            if (dmem_req_i && port_ack[sel_dec]) begin
                sel_d   = sel_dec;
                state_d = WAIT;
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
        end
        if (!rst_n) begin
            dmem_resp_o  = SCR1_MEM_RESP_NOTRDY;
            dmem_rdata_o = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= SCR1_SEL_PORT0;
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign port0_req_o   = port_req[0];
    assign port1_req_o   = port_req[1];
    assign port2_req_o   = port_req[2];
    assign port0_cmd_o   = dmem_cmd_i;
    assign port1_cmd_o   = dmem_cmd_i;
    assign port2_cmd_o   = dmem_cmd_i;
    assign port0_width_o = dmem_width_i;
    assign port1_width_o = dmem_width_i;
    assign port2_width_o = dmem_width_i;
    assign port0_addr_o  = dmem_addr_i;
    assign port1_addr_o  = dmem_addr_i;
    assign port2_addr_o  = dmem_addr_i;
    assign port0_wdata_o = dmem_wdata_i;
    assign port1_wdata_o = dmem_wdata_i;
    assign port2_wdata_o = dmem_wdata_i;

endmodule

// File: tb/tb_scr1_dmem_router.sv
// Randomized bench for scr1_dmem_router against a transaction-level model.
// Honours SCR1_DMEM_ROUTER_TIMEOUT_EN with a 16-cycle response timeout.
module tb_scr1_dmem_router;
    import scr1_memif_pkg::*;

    localparam int TO     = 16;
    localparam int CYCLES = 3000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e wid;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic                 ack_o;
    logic [31:0]          rdata_o;
    type_scr1_mem_resp_e  resp_o;
    logic [2:0]           preq;
    type_scr1_mem_cmd_e   pcmd [3];
    type_scr1_mem_width_e pwid [3];
    logic [31:0]          paddr [3];
    logic [31:0]          pwdata [3];
    logic                 ak [3];
    logic [31:0]          rd [3];
    type_scr1_mem_resp_e  rs [3];

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scr1_dmem_router dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dmem_req_i      (req),
        .dmem_cmd_i      (cmd),
        .dmem_width_i    (wid),
        .dmem_addr_i     (addr),
        .dmem_wdata_i    (wdata),
        .dmem_req_ack_o  (ack_o),
        .dmem_rdata_o    (rdata_o),
        .dmem_resp_o     (resp_o),
        .port0_req_o     (preq[0]),
        .port0_cmd_o     (pcmd[0]),
        .port0_width_o   (pwid[0]),
        .port0_addr_o    (paddr[0]),
        .port0_wdata_o   (pwdata[0]),
        .port0_req_ack_i (ak[0]),
        .port0_rdata_i   (rd[0]),
        .port0_resp_i    (rs[0]),
        .port1_req_o     (preq[1]),
        .port1_cmd_o     (pcmd[1]),
        .port1_width_o   (pwid[1]),
        .port1_addr_o    (paddr[1]),
        .port1_wdata_o   (pwdata[1]),
        .port1_req_ack_i (ak[1]),
        .port1_rdata_i   (rd[1]),
        .port1_resp_i    (rs[1]),
        .port2_req_o     (preq[2]),
        .port2_cmd_o     (pcmd[2]),
        .port2_width_o   (pwid[2]),
        .port2_addr_o    (paddr[2]),
        .port2_wdata_o   (pwdata[2]),
        .port2_req_ack_i (ak[2]),
        .port2_rdata_i   (rd[2]),
        .port2_resp_i    (rs[2])
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int target_of(input logic [31:0] a);
        if ((a & 32'hFFFF_0000) == 32'h0048_0000) return 1;
        if ((a & 32'hFFFF_FFE0) == 32'h0049_0000) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 3))
            0: a = 32'h0048_0000 | (a & 32'h0000_FFFF);
            1: a = 32'h0049_0000 | (a & 32'h0000_003F);
            2: a = 32'h0049_0000 ^ (32'h1 << $urandom_range(5, 31));
            default: ;
        endcase
        return a;
    endfunction

    function automatic type_scr1_mem_resp_e rand_resp(input int pct);
        int r;
        r = $urandom_range(0, 99);
        if (r >= pct) return SCR1_MEM_RESP_NOTRDY;
        return (r % 4 == 0) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    endfunction

    // Model: which port owns the outstanding transaction (-1 = none),
    // how many silent cycles it has waited, and whether it was abandoned.
    int  own    = -1;
    int  waited = 0;
    bit  abrt   = 1'b0;
    int  hits [3] = '{0, 0, 0};

    initial begin
        int  pct;
        int  d;
        bit  fwd;
        bit  tmo;
        logic [2:0]  e_req;
        logic        e_ack;
        logic [31:0] e_rdata;
        type_scr1_mem_resp_e e_resp;

        rst_n = 1'b0;
        req   = 1'b0;
        cmd   = SCR1_MEM_CMD_RD;
        wid   = SCR1_MEM_WIDTH_WORD;
        addr  = '0;
        wdata = '0;
        for (int p = 0; p < 3; p++) begin
            ak[p] = 1'b1;
            rd[p] = 32'hFFFF_FFFF;
            rs[p] = SCR1_MEM_RESP_RDY_OK;
        end

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            pct   = (cyc < 1000) ? 50 : (cyc < 2000) ? 10 : 3;
            rst_n = (cyc < 3) ? 1'b0 : ($urandom_range(0, 149) != 0);
            req   = $urandom_range(0, 3) != 0;
            cmd   = type_scr1_mem_cmd_e'($urandom_range(0, 1));
            wid   = type_scr1_mem_width_e'($urandom_range(0, 2));
            addr  = rand_addr();
            wdata = $urandom;
            for (int p = 0; p < 3; p++) begin
                ak[p] = $urandom_range(0, 2) != 0;
                rd[p] = $urandom;
                rs[p] = rand_resp(pct);
            end
            #2;
            e_req   = '0;
            e_ack   = 1'b0;
            e_resp  = SCR1_MEM_RESP_NOTRDY;
            e_rdata = '0;
            fwd     = 1'b0;
            tmo     = 1'b0;
            d       = target_of(addr);
            if (rst_n && !abrt) begin
                if (own < 0) begin
                    fwd = 1'b1;
                end else begin
                    e_rdata = rd[own];
                    if (rs[own] != SCR1_MEM_RESP_NOTRDY) begin
                        e_resp = rs[own];
                        fwd    = 1'b1;
                    end
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
                    else if (waited == TO - 1) begin
                        e_resp = SCR1_MEM_RESP_RDY_ER;
                        tmo    = 1'b1;
                    end
`endif
                end
                if (fwd) begin
                    e_req[d] = req;
                    e_ack    = req & ak[d];
                end
            end
            check("port_req", 32'(preq), 32'(e_req));
            check("req_ack", 32'(ack_o), 32'(e_ack));
            check("resp", 32'(resp_o), 32'(e_resp));
            check("rdata", rdata_o, e_rdata);
            check("addr_pass", paddr[cyc % 3], addr);
            check("wdata_pass", pwdata[(cyc + 1) % 3], wdata);
            check("cmd_width_pass", {30'd0, pcmd[(cyc + 2) % 3]} ^ {28'd0, pwid[cyc % 3], 2'd0},
                  {30'd0, cmd} ^ {28'd0, wid, 2'd0});

            @(posedge clk);
            if (!rst_n) begin
                own    = -1;
                waited = 0;
                abrt   = 1'b0;
            end else if (abrt) begin
                if (rs[own] != SCR1_MEM_RESP_NOTRDY) begin
                    abrt = 1'b0;
                    own  = -1;
                end
            end else if (fwd) begin
                if (e_ack) begin
                    own    = d;
                    waited = 0;
                    hits[d]++;
                end else begin
                    own = -1;
                end
            end else if (tmo) begin
                abrt = 1'b1;
            end else begin
                waited++;
            end
        end

        check("port0_used", 32'(hits[0] > 0), 32'd1);
        check("port1_used", 32'(hits[1] > 0), 32'd1);
        check("port2_used", 32'(hits[2] > 0), 32'd1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
